// File: rtl/pipeline_types_pkg.sv
// Types shared across the pipeline memory blocks: the data-memory responder
// FSM encoding and the width of its wait-state counter.
package pipeline_types;

  localparam int DMEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: byte-lane write enables on the clock edge,
// combinational read so the responder can present data in its RESP cycle.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic             iClk,
  input  logic             iWe,
  input  logic [3:0]       iBe,
  input  logic [IDX_W-1:0] iWIdx,
  input  logic [31:0]      iWData,
  input  logic [IDX_W-1:0] iRIdx,
  output logic [31:0]      oRData
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Contents survive reset, so the array has no reset term at all.
  always_ff @(posedge iClk) begin
    if (iWe) begin
      for (int b = 0; b < 4; b++) begin
        if (iBe[b]) begin
          mem_q[iWIdx][b*8 +: 8] <= iWData[b*8 +: 8];
        end
      end
    end
  end

  assign oRData = mem_q[iRIdx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: captures one request, waits WAIT_CYCLES,
// then acknowledges for a single cycle with load data or an access fault.
module dmem_responder
  import pipeline_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  input  logic [3:0]  iBe,
  output logic        oStall,
  output logic        oAck,
  output logic [31:0] oRData,
  output logic        oErr
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
  localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? DMEM_WAIT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_t             state_q, state_d;
  logic [DMEM_WAIT_W-1:0]  cnt_q, cnt_d;
  logic                    latch;
  logic                    we_q;
  logic [IDX_W-1:0]        idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    oor_q;
  logic                    oor_now;
  logic                    arr_we;
  logic [31:0]             arr_rdata;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^iAddr[1:0];
  assign oor_now         = ({2'b00, iAddr[31:2]} >= DEPTH_U);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iReq) begin
          latch = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        // A withdrawn request is abandoned silently; nothing is written.
        if (!iReq) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - DMEM_WAIT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        we_q    <= iWe;
        idx_q   <= iAddr[IDX_W+1:2];
        wdata_q <= iWData;
        be_q    <= iBe;
        oor_q   <= oor_now;
      end
    end
  end

  assign oAck   = (state_q == RESP);
  assign oErr   = oAck & oor_q;
  assign oRData = (oAck && !we_q && !oor_q) ? arr_rdata : 32'h0;
  assign oStall = iReq & ~oAck;
  assign arr_we = oAck & we_q & ~oor_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .iClk   (iClk),
    .iWe    (arr_we),
    .iBe    (be_q),
    .iWIdx  (idx_q),
    .iWData (wdata_q),
    .iRIdx  (idx_q),
    .oRData (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for latency,
// merging, fault and reset scenarios, plus a WAIT_CYCLES=0 instance for throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, we, req0, we0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic [3:0]  be, be0;
  logic        stall, ack, err, stall0, ack0, err0;
  logic [31:0] rdata, rdata0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .iClk(clk), .iRst(rst), .iReq(req), .iWe(we), .iAddr(addr), .iWData(wdata),
    .iBe(be), .oStall(stall), .oAck(ack), .oRData(rdata), .oErr(err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .iClk(clk), .iRst(rst), .iReq(req0), .iWe(we0), .iAddr(addr0), .iWData(wdata0),
    .iBe(be0), .oStall(stall0), .oAck(ack0), .oRData(rdata0), .oErr(err0)
  );

  bit          sel;
  logic        m_stall, m_ack, m_err;
  logic [31:0] m_rdata;
  assign m_stall = sel ? stall0 : stall;
  assign m_ack   = sel ? ack0   : ack;
  assign m_err   = sel ? err0   : err;
  assign m_rdata = sel ? rdata0 : rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Issues one request starting at a falling edge and returns when the FSM
  // is back in IDLE at a falling edge. scr perturbs the inputs mid-WAIT.
  task automatic run_access(input bit s, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, input bit scr,
                            output int ack_cyc, output int stall_cnt,
                            output logic [31:0] rd, output logic er, output int glitch);
    sel = s;
    if (s) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b; end
    else   begin req  = 1'b1; we  = w; addr  = a; wdata  = d; be  = b; end
    #1;
    ack_cyc = -1; stall_cnt = 0; rd = 32'h0; er = 1'b0; glitch = 0;
    for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (scr && c == 1) begin
        we = ~w; addr = 32'h0000_0010; wdata = 32'hFFFF_FFFF; be = 4'hF;
      end
      if (m_stall) stall_cnt++;
      if (m_ack) begin ack_cyc = c; rd = m_rdata; er = m_err; end
      else if (m_err || m_rdata != 32'h0) glitch++;
    end
    if (s) req0 = 1'b0; else req = 1'b0;
    @(negedge clk);
    if (m_ack || m_err || m_rdata != 32'h0) glitch++;
    $display("access dut%0d we=%0b addr=%h wdata=%h be=%b -> ack@%0d stall=%0d rdata=%h err=%0b",
             s ? 0 : 2, w, a, d, b, ack_cyc, stall_cnt, rd, er);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_cmp++; if (u_dut.state_q !== pipeline_types::IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want IDLE", u_dut.state_q); end
    n_cmp++; if (u_dut.cnt_q !== 4'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", u_dut.cnt_q); end
    req = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall_follows: got %b want 1", stall); end
    @(negedge clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rst_hold_ack: got %b want 0", ack); end
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int ac, sc, gl; logic [31:0] rd; logic er;
    run_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL st_ack_cycle: got %0d want 3", ac); end
    n_cmp++; if (sc !== 3) begin n_bad++; $display("FAIL st_stall_cycles: got %0d want 3", sc); end
    n_cmp++; if (er !== 1'b0 || gl !== 0) begin n_bad++; $display("FAIL st_err_glitch: got err=%b glitch=%0d want 0/0", er, gl); end
    run_access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL ld_ack_cycle: got %0d want 3", ac); end
    n_cmp++; if (sc !== 3) begin n_bad++; $display("FAIL ld_stall_cycles: got %0d want 3", sc); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (gl !== 0) begin n_bad++; $display("FAIL ld_glitch: got %0d want 0", gl); end
    // inputs scrambled during WAIT must not affect the latched store
    run_access(0, 1'b1, 32'h14, 32'h01020304, 4'hF, 1'b1, ac, sc, rd, er, gl);
    run_access(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'h01020304) begin n_bad++; $display("FAIL latch_target: got %h want 01020304", rd); end
    run_access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL latch_other: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_merge();
    int ac, sc, gl; logic [31:0] rd; logic er;
    run_access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, ac, sc, rd, er, gl);
    run_access(0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, 1'b0, ac, sc, rd, er, gl);
    run_access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'h1122AA44) begin n_bad++; $display("FAIL merge_lane1: got %h want 1122aa44", rd); end
    run_access(0, 1'b1, 32'h20, 32'hAB0000CD, 4'b1001, 1'b0, ac, sc, rd, er, gl);
    run_access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'hAB22AACD) begin n_bad++; $display("FAIL merge_lane30: got %h want ab22aacd", rd); end
    run_access(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (ac !== 3 || er !== 1'b0) begin n_bad++; $display("FAIL be0_ack: got ack@%0d err=%b want 3/0", ac, er); end
    run_access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'hAB22AACD) begin n_bad++; $display("FAIL be0_noop: got %h want ab22aacd", rd); end
  endtask

  task automatic test_out_of_range();
    int ac, sc, gl; logic [31:0] rd; logic er;
    run_access(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, ac, sc, rd, er, gl);
    run_access(0, 1'b1, 32'hFFC, 32'h600DCAFE, 4'hF, 1'b0, ac, sc, rd, er, gl);
    run_access(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (ac !== 3 || er !== 1'b1) begin n_bad++; $display("FAIL oor_ld_err: got ack@%0d err=%b want 3/1", ac, er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_ld_rdata: got %h want 0", rd); end
    run_access(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (ac !== 3 || er !== 1'b1) begin n_bad++; $display("FAIL oor_st_err: got ack@%0d err=%b want 3/1", ac, er); end
    run_access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin n_bad++; $display("FAIL oor_no_write: got %h err=%b want 0badf00d/0", rd, er); end
    run_access(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'h600DCAFE || er !== 1'b0) begin n_bad++; $display("FAIL last_word: got %h err=%b want 600dcafe/0", rd, er); end
    run_access(0, 1'b0, 32'h80000000, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL oor_high: got %h err=%b want 0/1", rd, er); end
  endtask

  task automatic test_back_to_back();
    int ac, sc, gl, acks; logic [31:0] rd; logic er; logic exp_ack;
    run_access(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (ac !== 1 || sc !== 1) begin n_bad++; $display("FAIL w0_store: got ack@%0d stall=%0d want 1/1", ac, sc); end
    sel = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; acks = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_ack = (c % 2 == 1);
      n_cmp++; if (ack0 !== exp_ack || stall0 !== !exp_ack) begin n_bad++; $display("FAIL b2b_c%0d: got ack=%b stall=%b want %b/%b", c, ack0, stall0, exp_ack, !exp_ack); end
      if (ack0) begin
        acks++;
        n_cmp++; if (rdata0 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_rdata: got %h want cafef00d", rdata0); end
      end
    end
    req0 = 1'b0;
    n_cmp++; if (acks !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", acks); end
    $display("access dut0 back-to-back loads addr=00000040 -> %0d acks", acks);
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_during_wait();
    int ac, sc, gl; logic [31:0] rd; logic er;
    run_access(0, 1'b1, 32'h8, 32'h12345678, 4'hF, 1'b0, ac, sc, rd, er, gl);
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h55; be = 4'hF;
    @(negedge clk); #1;
    n_cmp++; if (u_dut.state_q !== pipeline_types::WAIT) begin n_bad++; $display("FAIL rw_in_wait: got %0d want WAIT", u_dut.state_q); end
    rst = 1'b1; #1;
    n_cmp++; if (ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin n_bad++; $display("FAIL rw_outputs: got ack=%b err=%b rdata=%h want 0", ack, err, rdata); end
    n_cmp++; if (u_dut.state_q !== pipeline_types::IDLE || u_dut.cnt_q !== 4'd0) begin n_bad++; $display("FAIL rw_state: got %0d cnt=%0d want IDLE/0", u_dut.state_q, u_dut.cnt_q); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rw_stall_follows: got %b want 1", stall); end
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_access(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'h12345678 || ac !== 3) begin n_bad++; $display("FAIL rw_no_write: got %h ack@%0d want 12345678/3", rd, ac); end
  endtask

  task automatic test_drop_in_wait();
    int ac, sc, gl, seen; logic [31:0] rd; logic er;
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h99999999; be = 4'hF;
    @(negedge clk); #1;
    req = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (u_dut.state_q !== pipeline_types::IDLE) begin n_bad++; $display("FAIL drop_idle: got %0d want IDLE", u_dut.state_q); end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (ack || err) seen++;
      @(negedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL drop_no_ack: got %0d acks want 0", seen); end
    @(negedge clk);
    run_access(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, ac, sc, rd, er, gl);
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL drop_no_write: got %h want 12345678", rd); end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    test_reset();
    test_store_load();
    test_byte_merge();
    test_out_of_range();
    test_back_to_back();
    test_reset_during_wait();
    test_drop_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words backing the data memory.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra wait states inserted before each response (0..15 legal).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port iClk, input, 1, rising-edge clock.
REQ-005 SHALL have port iRst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port iReq, input, 1, MEM-stage access request, held stable until oAck.
REQ-007 SHALL have port iWe, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port iAddr, input, 32, byte address; bits [1:0] ignored for indexing.
REQ-009 SHALL have port iWData, input, 32, store data, lane-aligned.
REQ-010 SHALL have port iBe, input, 4, store byte enables, bit n = byte lane n.
REQ-011 SHALL have port oStall, output, 1, stall to pipeline while a request is outstanding.
REQ-012 SHALL have port oAck, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port oRData, output, 32, full word read data, valid with oAck on loads.
REQ-014 SHALL have port oErr, output, 1, access fault, valid with oAck.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
- IDLE: iReq=1 -> WAIT if WAIT_CYCLES>0, else RESP; wait counter loaded with WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; at 0 -> RESP.
- RESP: oAck=1 for exactly one cycle -> IDLE.
REQ-016 SHALL latch iWe, iAddr, iWData, iBe at the IDLE->WAIT/RESP edge; later input changes are ignored until the next IDLE.
REQ-017 SHALL assert oAck exactly WAIT_CYCLES+1 cycles after the cycle in which iReq is first sampled high in IDLE.
REQ-018 SHALL drive oStall = iReq & ~oAck (combinational), so the pipeline advances in the oAck cycle.
REQ-019 SHALL, on a store in RESP, write only the byte lanes with iBe bit set at the RESP clock edge; iBe=0000 is a legal no-op store acknowledged normally.
REQ-020 SHALL, on a load, drive oRData with the stored word at the latched index during RESP and 0 in all other cycles.
REQ-021 SHALL ensure a load issued after an acknowledged store to the same word returns the merged new data.
REQ-022 SHALL flag word index (iAddr[31:2]) >= DEPTH_WORDS as out of range: oErr=1 with oAck, no write performed, oRData=0.
REQ-023 SHALL, if iReq drops in WAIT (protocol violation), return to IDLE next cycle without writing and without oAck.
REQ-024 SHALL, if iReq remains high after oAck, treat it as a new request (IDLE sample next cycle); back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-025 SHALL keep oErr=0 and oAck=0 outside RESP.

Reset
REQ-026 SHALL, on iRst=1 at any time, immediately force state=IDLE, counter=0, oAck=0, oErr=0, oRData=0; oStall then follows iReq.
REQ-027 SHALL NOT clear memory contents on reset; a store interrupted by reset before its RESP edge SHALL not be written.

Structure
REQ-028 SHALL place the FSM state enum (dmem_state_t) and DMEM_WAIT_W counter width constant in the shared pipeline_types package.
REQ-029 SHALL instantiate one sub-module dmem_array: synchronous byte-enable-write, asynchronous-read word array sized by DEPTH_WORDS.

Verification
REQ-030 SHALL cover: WAIT_CYCLES=2, store 0xDEADBEEF to 0x10 with iBe=1111, then load 0x10 -> oAck at cycle 3 of each request, oRData=0xDEADBEEF, oStall high exactly 3 cycles per request.
REQ-031 SHALL cover: word 0x20 holds 0x11223344, store 0x0000AA00 with iBe=0010 -> subsequent load returns 0x1122AA44.
REQ-032 SHALL cover: DEPTH_WORDS=1024, load from 0x00001000 -> oAck with oErr=1, oRData=0; store to the same address leaves the array unchanged.
REQ-033 SHALL cover: WAIT_CYCLES=0, iReq held high for 6 cycles of loads -> oAck every 2nd cycle, three acks.
REQ-034 SHALL cover: store 0x55 to 0x8 issued, iRst pulsed during WAIT -> outputs 0 immediately, state IDLE; later load of 0x8 returns prior contents.
REQ-035 SHALL cover: iReq dropped during WAIT -> no oAck, no write, FSM back in IDLE the next cycle.
